// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        VALID
    } state_e;

    typedef enum logic [1:0] {
        F_NONE,
        F_MISALIGN,
        F_BUSERR,
        F_TIMEOUT
    } fault_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_hit_buf.sv
// Single-entry fetch hit buffer {valid, word address, data}.
// Invalidate takes priority over a write in the same cycle.
module ifetch_hit_buf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inv,
    input  logic        i_wr_en,
    input  logic [29:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [29:0] i_lookup_addr,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [29:0] r_addr;
    logic [31:0] r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            if (i_wr_en) begin
                r_valid <= 1'b1;
                r_addr  <= i_wr_addr;
                r_data  <= i_wr_data;
            end
            if (i_inv) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_hit  = r_valid & (r_addr == i_lookup_addr);
    assign o_data = r_data;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: PC -> imem req/gnt/rvalid -> decode valid/ready.
// Define IFETCH_HIT_BUF_EN to enable the one-entry hit buffer (and the inv input).
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR      = NOP,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        fetch_req,
    input  logic        flush,
    input  logic        inv,
    output logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        r_state;
    fault_e        r_cause;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [31:0]   r_instr_pc;
    logic          r_instr_valid;
    logic          r_fault;
    logic          r_imem_req;
    logic          r_discard;
    logic [CW-1:0] r_cnt;

    logic [CW-1:0] w_cnt_inc;
    logic          w_timeout;
    logic          w_misalign;
    logic          w_hit;
    logic [31:0]   w_hb_data;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_timeout  = (w_cnt_inc == CW'(TIMEOUT_CYCLES));
    assign w_misalign = |pc_in[1:0];

`ifdef IFETCH_HIT_BUF_EN
    logic w_hb_hit;
    logic w_hb_wr;

    assign w_hb_wr = (r_state == WAIT) & imem_rvalid & ~imem_err;
    assign w_hit   = w_hb_hit & ~w_misalign;

    ifetch_hit_buf u_hit_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_inv         (inv),
        .i_wr_en       (w_hb_wr),
        .i_wr_addr     (r_pc[31:2]),
        .i_wr_data     (imem_rdata),
        .i_lookup_addr (pc_in[31:2]),
        .o_hit         (w_hb_hit),
        .o_data        (w_hb_data)
    );
`else
    logic w_unused_inv;

    assign w_unused_inv = inv;
    assign w_hit        = 1'b0;
    assign w_hb_data    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cause       <= F_NONE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_imem_req    <= 1'b0;
            r_discard     <= 1'b0;
            r_cnt         <= '0;
        end else begin
            unique case (r_state)
                // VALID shares IDLE's launch path so an accepted word can chain
                // straight into the next fetch without an idle bubble.
                IDLE, VALID: begin
                    if (flush) begin
                        r_state       <= IDLE;
                        r_instr_valid <= 1'b0;
                    end else if (r_state == IDLE || instr_ready) begin
                        r_state       <= IDLE;
                        r_instr_valid <= 1'b0;
                        if (fetch_req) begin
                            r_pc <= pc_in;
                            if (w_misalign) begin
                                r_state       <= VALID;
                                r_instr_valid <= 1'b1;
                                r_instr       <= NOP_INSTR;
                                r_instr_pc    <= pc_in;
                                r_fault       <= 1'b1;
                                r_cause       <= F_MISALIGN;
                            end else if (w_hit) begin
                                r_state       <= VALID;
                                r_instr_valid <= 1'b1;
                                r_instr       <= w_hb_data;
                                r_instr_pc    <= pc_in;
                                r_fault       <= 1'b0;
                                r_cause       <= F_NONE;
                            end else begin
                                r_state    <= REQ;
                                r_imem_req <= 1'b1;
                            end
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (imem_gnt) begin
                        r_state    <= WAIT;
                        r_imem_req <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (imem_rvalid || w_timeout) begin
                        if (r_discard || flush) begin
                            r_discard <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_state       <= VALID;
                            r_instr_valid <= 1'b1;
                            r_instr_pc    <= r_pc;
                            if (imem_rvalid) begin
                                r_instr <= imem_err ? NOP_INSTR : imem_rdata;
                                r_fault <= imem_err;
                                r_cause <= imem_err ? F_BUSERR : F_NONE;
                            end else begin
                                r_instr <= NOP_INSTR;
                                r_fault <= 1'b1;
                                r_cause <= F_TIMEOUT;
                            end
                        end
                    end else if (flush) begin
                        r_discard <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign stall       = fetch_req & ~(r_instr_valid & instr_ready);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fetch_fault = r_fault;
    assign fault_cause = r_cause;
    assign imem_req    = r_imem_req;
    assign imem_addr   = {r_pc[31:2], 2'b00};

endmodule
